// File: rtl/ryuki_datatypes.sv
`default_nettype none
// ============================================================================
// Module      : ryuki_datatypes (package)
// Description : Shared datatypes for the ryuki core and its trace path.
//               trace_output is the record emitted by trace_unit and stored
//               by trace_sink. TRACE_SINK_DEPTH is the default sink depth,
//               shared by trace_unit integration and the benches.
// Revision    : 1.0 - initial release
// ============================================================================
package ryuki_datatypes;

    localparam int TRACE_SINK_DEPTH = 16;

    // One retired-instruction trace record.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_output;

endpackage : ryuki_datatypes
`default_nettype wire

// File: rtl/trace_sink_mem.sv
`default_nettype none
// ============================================================================
// Module      : trace_sink_mem
// Description : Simple dual-port DEPTH x trace_output record store.
//               Synchronous write, asynchronous read. No reset on the array
//               so that it maps onto distributed (LUT) RAM.
// Ports       : clk      - clock
//               we       - write enable
//               waddr    - write slot
//               wdata    - record to write
//               raddr    - read slot
//               rdata    - record at raddr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module trace_sink_mem
    import ryuki_datatypes::*;
#(
    parameter int DEPTH = TRACE_SINK_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  trace_output              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output trace_output              rdata
);

    trace_output r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : trace_sink_mem
`default_nettype wire

// File: rtl/trace_sink.sv
`default_nettype none
// ============================================================================
// Module      : trace_sink
// Description : Receiving end of the trace path. Captures one trace_output
//               record per strobe cycle into a FIFO and hands records to a
//               downstream consumer over valid/ready. The trace unit is never
//               stalled: records arriving while full are dropped, counted
//               (saturating) and flagged with a sticky overflow bit.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               trace_data_ready   - record strobe (push)
//               trace_data_i       - record payload
//               rec_valid/rec_ready/rec_data - consumer handshake, oldest record
//               level              - records stored, 0..DEPTH
//               overflow           - sticky drop flag
//               drop_count         - saturating dropped-record counter
//               clear_overflow     - clears overflow and drop_count
// Revision    : 1.0 - initial release
// ============================================================================
module trace_sink
    import ryuki_datatypes::*;
#(
    parameter int DEPTH     = TRACE_SINK_DEPTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_data_ready,
    input  trace_output              trace_data_i,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output trace_output              rec_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     drop_count,
    input  logic                     clear_overflow
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam logic [c_lw-1:0] c_full_level = c_lw'(DEPTH);

    logic [c_aw-1:0]      r_wptr;
    logic [c_aw-1:0]      r_rptr;
    logic [c_lw-1:0]      r_level;
    logic                 r_overflow;
    logic [CNT_WIDTH-1:0] r_drop_count;

    logic        w_pop;
    logic        w_full;
    logic        w_accept;
    logic        w_drop;
    trace_output w_rd_data;

    assign rec_valid = (r_level != '0);
    assign w_pop     = rec_valid && rec_ready;
    assign w_full    = (r_level == c_full_level);
    // When full, a simultaneous pop frees the slot the write lands in.
    assign w_accept  = trace_data_ready && (!w_full || w_pop);
    assign w_drop    = trace_data_ready && w_full && !w_pop;

    trace_sink_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_accept && !rst),
        .waddr (r_wptr),
        .wdata (trace_data_i),
        .raddr (r_rptr),
        .rdata (w_rd_data)
    );

    // Storage is not reset, so mask stale slot contents while empty.
    assign rec_data   = rec_valid ? w_rd_data : '0;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    // Pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + 1'b1;
            if (w_pop)    r_rptr <= r_rptr + 1'b1;
            unique case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A clear coinciding with a drop clears the flag but still counts the
    // new drop, so the counter restarts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= w_drop ? CNT_WIDTH'(1) : '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (!(&r_drop_count)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

endmodule : trace_sink
`default_nettype wire

// File: tb/tb_trace_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_sink
// Description : Scoreboard bench for trace_sink. The driver pushes expected
//               records into a queue when they should be accepted; a monitor
//               pops and compares on every handshake. Status outputs are
//               checked against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_sink;
    import ryuki_datatypes::*;

    localparam int DEPTH     = 16;
    localparam int CNT_WIDTH = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   trace_data_ready;
    trace_output            trace_data_i;
    logic                   rec_valid;
    logic                   rec_ready;
    trace_output            rec_data;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic [CNT_WIDTH-1:0]   drop_count;
    logic                   clear_overflow;

    int checks = 0;
    int errors = 0;
    int max_level = 0;
    trace_output exp_q[$];

    trace_sink #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .trace_data_ready (trace_data_ready),
        .trace_data_i     (trace_data_i),
        .rec_valid        (rec_valid),
        .rec_ready        (rec_ready),
        .rec_data         (rec_data),
        .level            (level),
        .overflow         (overflow),
        .drop_count       (drop_count),
        .clear_overflow   (clear_overflow)
    );

    always #5 clk = ~clk;

    function automatic trace_output mk(input int v);
        trace_output t;
        t.pc    = 32'(v);
        t.instr = 32'(v) ^ 32'hA5A5_0000;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must deliver the next expected record.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", rec_data);
            end else begin
                chk("pop_data", rec_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(level) > max_level) max_level = int'(level);
    endtask

    task automatic strobe(input int v, input bit accepted);
        trace_data_ready = 1'b1;
        trace_data_i     = mk(v);
        if (accepted) exp_q.push_back(mk(v));
    endtask

    task automatic idle();
        trace_data_ready = 1'b0;
        trace_data_i     = '0;
    endtask

    task automatic drain();
        int n = 0;
        rec_ready = 1'b1;
        while (level != 0 && n < 64) begin
            tick();
            n++;
        end
        rec_ready = 1'b0;
        chk("drain_done", 64'(level), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rec_ready = 1'b0; clear_overflow = 1'b0;
        idle();
        tick(); tick();
        rst = 1'b0;
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_valid", 64'(rec_valid), 64'd0);
        chk("reset_data", rec_data, 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_drops", 64'(drop_count), 64'd0);

        // Back-to-back strobes with consumer always ready.
        max_level = 0;
        rec_ready = 1'b1;
        strobe(32'h11, 1'b1); tick();
        chk("latency_valid", 64'(rec_valid), 64'd1);
        strobe(32'h22, 1'b1); tick();
        strobe(32'h33, 1'b1); tick();
        idle(); tick();
        chk("stream_empty", 64'(level), 64'd0);
        chk("stream_peak", 64'(max_level), 64'd1);
        rec_ready = 1'b0;
        tick();

        // Overrun: 18 strobes into 16 slots.
        for (int i = 0; i < 18; i++) begin
            strobe(i, i < DEPTH); tick();
        end
        idle(); tick();
        chk("full_level", 64'(level), 64'd16);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_drops", 64'(drop_count), 64'd2);

        // Full with simultaneous push and pop: accepted, nothing dropped.
        strobe(100, 1'b1); rec_ready = 1'b1; tick();
        idle(); rec_ready = 1'b0;
        chk("fullpp_level", 64'(level), 64'd16);
        chk("fullpp_drops", 64'(drop_count), 64'd2);

        // Stall: data must hold, then exactly one pop.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data", rec_data, mk(1));
        end
        rec_ready = 1'b1; tick(); rec_ready = 1'b0;
        chk("single_pop_level", 64'(level), 64'd15);
        chk("single_pop_data", rec_data, mk(2));
        drain();

        // Clear, then saturate the 2-bit counter with 5 drops.
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        chk("clear_overflow", 64'(overflow), 64'd0);
        chk("clear_drops", 64'(drop_count), 64'd0);
        for (int i = 0; i < 21; i++) begin
            strobe(200 + i, i < DEPTH); tick();
        end
        idle(); tick();
        chk("sat_drops", 64'(drop_count), 64'd3);
        chk("sat_overflow", 64'(overflow), 64'd1);
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        chk("clear2_overflow", 64'(overflow), 64'd0);
        chk("clear2_drops", 64'(drop_count), 64'd0);

        // Clear coinciding with a drop, then a following drop.
        strobe(250, 1'b0); clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        chk("clrdrop_overflow", 64'(overflow), 64'd0);
        chk("clrdrop_drops", 64'(drop_count), 64'd1);
        strobe(251, 1'b0); tick(); idle();
        chk("nextdrop_overflow", 64'(overflow), 64'd1);
        chk("nextdrop_drops", 64'(drop_count), 64'd2);
        drain();

        // Reset with 7 stored records and a strobe in the reset cycle.
        for (int i = 0; i < 7; i++) begin
            strobe(300 + i, 1'b1); tick();
        end
        idle();
        chk("prereset_level", 64'(level), 64'd7);
        strobe(999, 1'b0); rst = 1'b1; tick();
        rst = 1'b0; idle();
        exp_q.delete();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(rec_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drops", 64'(drop_count), 64'd0);
        chk("rst_data", rec_data, 64'd0);
        tick();
        chk("rst_no_strobe", 64'(level), 64'd0);
        strobe(42, 1'b1); tick(); idle();
        chk("post_rst_data", rec_data, mk(42));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_trace_sink
`default_nettype wire
